atividade_cinco_pio_in: RTL and testbench

//  Avalon-MM slave input PIO: the read-side counterpart of the system's 8-bit output PIO.
//  - Samples an external WIDTH-bit bus (switches/keys) through a 2-flop synchronizer and an optional per-bit debounce filter.
//  - Latches selected edges into a sticky capture register.
//  - Raises a level interrupt to the Nios II for unmasked captured edges.

---
 rtl/atividade_cinco_pio_in.sv | 80 ++++++++
 tb/tb_atividade_cinco_pio_in.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/atividade_cinco_pio_in.sv
// atividade_cinco_pio_in: Avalon-MM input PIO with synchronizer, optional debounce, sticky edge capture and irq.
// Read data is registered one cycle after the address; edgecapture is write-1-to-clear with set priority.
module atividade_cinco_pio_in #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] s1_q, s2_q, filt_q, filt_d, prev_q, mask_q, mask_d, ec_q, ec_d, edge_w, wdata_w;
    logic [31:0] rd_d;
    logic wr, wr_mask, wr_clr, unused_wdata;
    assign wr           = chipselect & ~write_n;
    assign wr_mask      = wr && address == 2'd1;
    assign wr_clr       = wr && address == 2'd3;
    assign wdata_w      = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filt_d = s2_q;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt_q [WIDTH];
            logic [CW-1:0] cnt_d [WIDTH];
            // A bit is accepted on the cycle its counter would reach DEBOUNCE_CYCLES.
            always_comb begin
                filt_d = filt_q;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i]  = (s2_q[i] == filt_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
                    filt_d[i] = (s2_q[i] != filt_q[i] && cnt_q[i] == LAST) ? s2_q[i] : filt_q[i];
                end
            end
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
                end
            end
        end
    endgenerate
    assign edge_w = EDGE_TYPE == 0 ? filt_q & ~prev_q :
                    EDGE_TYPE == 1 ? ~filt_q & prev_q : filt_q ^ prev_q;
    always_comb begin
        ec_d   = edge_w | (ec_q & ~({WIDTH{wr_clr}} & wdata_w));
        mask_d = wr_mask ? wdata_w : mask_q;
        rd_d   = address == 2'd0 ? 32'(filt_q) :
                 address == 2'd1 ? 32'(mask_q) :
                 address == 2'd3 ? 32'(ec_q)   : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            filt_q   <= '0;
            prev_q   <= '0;
            mask_q   <= '0;
            ec_q     <= '0;
            readdata <= '0;
        end else begin
            s1_q     <= in_port;
            s2_q     <= s1_q;
            filt_q   <= filt_d;
            prev_q   <= filt_q;
            mask_q   <= mask_d;
            ec_q     <= ec_d;
            readdata <= rd_d;
        end
    end
    assign irq = |(ec_q & mask_q);
endmodule

// File: tb/tb_atividade_cinco_pio_in.sv
// tb_atividade_cinco_pio_in: table-driven and hand-sequenced checks of three PIO configurations.
module tb_atividade_cinco_pio_in;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] address = 2'd0;
    logic cs_a = 1'b0, cs_b = 1'b0, cs_c = 1'b0;
    logic write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata_a, readdata_b, readdata_c;
    logic [7:0] in_a = 8'h00, in_b = 8'h00, in_c = 8'hFF;
    logic irq_a, irq_b, irq_c;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    atividade_cinco_pio_in dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a), .write_n(write_n),
        .writedata(writedata), .readdata(readdata_a), .in_port(in_a), .irq(irq_a));
    atividade_cinco_pio_in #(.DEBOUNCE_CYCLES(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b), .write_n(write_n),
        .writedata(writedata), .readdata(readdata_b), .in_port(in_b), .irq(irq_b));
    atividade_cinco_pio_in #(.EDGE_TYPE(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_c), .write_n(write_n),
        .writedata(writedata), .readdata(readdata_c), .in_port(in_c), .irq(irq_c));

    typedef struct {
        bit          wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  din;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;
    vec_t tbl [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wr(input int which, input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs_a      = which == 0;
        cs_b      = which == 1;
        cs_c      = which == 2;
        tick();
        write_n = 1'b1;
        cs_a    = 1'b0;
        cs_b    = 1'b0;
        cs_c    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick();
    endtask

    initial begin
        tbl[0]  = '{0, 2'd0, 32'h0,        8'h00, 2'd0, 32'h00, 1'b0};
        tbl[1]  = '{0, 2'd0, 32'h0,        8'h00, 2'd1, 32'h00, 1'b0};
        tbl[2]  = '{0, 2'd0, 32'h0,        8'h00, 2'd2, 32'h00, 1'b0};
        tbl[3]  = '{0, 2'd0, 32'h0,        8'h00, 2'd3, 32'h00, 1'b0};
        tbl[4]  = '{0, 2'd0, 32'h0,        8'hA5, 2'd0, 32'hA5, 1'b0};
        tbl[5]  = '{0, 2'd0, 32'h0,        8'hA5, 2'd3, 32'hA5, 1'b0};
        tbl[6]  = '{1, 2'd3, 32'h05,       8'hA5, 2'd3, 32'hA0, 1'b0};
        tbl[7]  = '{1, 2'd1, 32'hFFFFFF3C, 8'hA5, 2'd1, 32'h3C, 1'b1};
        tbl[8]  = '{1, 2'd2, 32'hFF,       8'hA5, 2'd2, 32'h00, 1'b1};
        tbl[9]  = '{1, 2'd0, 32'hFF,       8'hA5, 2'd0, 32'hA5, 1'b1};
        tbl[10] = '{0, 2'd0, 32'h0,        8'hA4, 2'd3, 32'hA0, 1'b1};
        tbl[11] = '{1, 2'd3, 32'hFF,       8'hA4, 2'd3, 32'h00, 1'b0};
        tbl[12] = '{0, 2'd0, 32'h0,        8'hFF, 2'd3, 32'h5B, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset rd_a", readdata_a, 32'h0);
        check("reset irq_a", {31'b0, irq_a}, 32'h0);
        @(negedge clk) reset_n = 1'b1;

        // Input held high through reset: falling-edge config captures nothing.
        repeat (4) tick();
        rd(2'd0);
        check("c post-reset data", readdata_c, 32'hFF);
        rd(2'd3);
        check("c post-reset ec", readdata_c, 32'h00);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) wr(0, tbl[i].waddr, tbl[i].wdata);
            in_a = tbl[i].din;
            repeat (4) tick();
            rd(tbl[i].raddr);
            check($sformatf("row%0d rd", i), readdata_a, tbl[i].exp_rd);
            check($sformatf("row%0d irq", i), {31'b0, irq_a}, {31'b0, tbl[i].exp_irq});
        end

        // irq follows mask and clear with no extra latency
        wr(0, 2'd3, 32'hFF);
        wr(0, 2'd1, 32'h01);
        in_a = 8'h00;
        repeat (5) tick();
        check("irq idle", {31'b0, irq_a}, 32'h0);
        in_a = 8'h01;
        tick();
        in_a = 8'h00;
        repeat (4) tick();
        check("irq pulse", {31'b0, irq_a}, 32'h1);
        wr(0, 2'd3, 32'h01);
        check("irq after clear", {31'b0, irq_a}, 32'h0);
        in_a = 8'h01;
        tick();
        in_a = 8'h00;
        repeat (4) tick();
        check("irq pulse2", {31'b0, irq_a}, 32'h1);
        wr(0, 2'd1, 32'h00);
        check("irq masked", {31'b0, irq_a}, 32'h0);
        rd(2'd3);
        check("ec kept when masked", readdata_a, 32'h01);

        // Edge and clear on bit 2 in the same cycle: set wins
        wr(0, 2'd3, 32'hFF);
        in_a = 8'h04;
        repeat (5) tick();
        in_a = 8'h00;
        repeat (5) tick();
        rd(2'd3);
        check("ec2 preset", readdata_a, 32'h04);
        in_a = 8'h04;
        repeat (3) tick();
        wr(0, 2'd3, 32'h04);
        rd(2'd3);
        check("set beats clear", readdata_a, 32'h04);
        wr(0, 2'd3, 32'h04);
        rd(2'd3);
        check("plain clear", readdata_a, 32'h00);

        // Debounce: a 3-cycle glitch is filtered out
        wr(1, 2'd1, 32'h02);
        rd(2'd0);
        in_b = 8'h02;
        repeat (3) tick();
        in_b = 8'h00;
        repeat (8) tick();
        check("glitch data", readdata_b, 32'h0);
        check("glitch irq", {31'b0, irq_b}, 32'h0);
        rd(2'd3);
        check("glitch ec", readdata_b, 32'h0);
        rd(2'd0);
        // A held level is accepted 2+4 clocks later and captured one clock after that
        in_b = 8'h02;
        repeat (6) tick();
        check("deb data early", readdata_b, 32'h0);
        check("deb irq early", {31'b0, irq_b}, 32'h0);
        tick();
        check("deb data", readdata_b, 32'h02);
        check("deb irq", {31'b0, irq_b}, 32'h1);

        // Falling-edge capture
        in_c = 8'h0F;
        repeat (4) tick();
        rd(2'd3);
        check("c falling ec", readdata_c, 32'hF0);

        // Asynchronous reset in the middle of a debounce count
        in_b = 8'h00;
        repeat (3) tick();
        check("pre-reset irq_b", {31'b0, irq_b}, 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async rd_c", readdata_c, 32'h0);
        check("async rd_b", readdata_b, 32'h0);
        check("async irq_b", {31'b0, irq_b}, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        repeat (6) tick();
        rd(2'd3);
        check("c ec after reset", readdata_c, 32'h0);
        check("b ec after reset", readdata_b, 32'h0);
        check("a post-reset rise", readdata_a, 32'h04);
        check("a irq after reset", {31'b0, irq_a}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
